// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg
// Shared definitions for the L1 -> L2 request arbiter:
//   MEM_LD / MEM_ST : L2 opcode values for load and store
//   arb_state_e     : arbiter FSM states (IDLE, REQ, WAIT_RSP)
//   client_e        : client identifiers (CLIENT_I, CLIENT_D)
package l1_arb_pkg;

  localparam logic [3:0] MEM_LD = 4'd4;
  localparam logic [3:0] MEM_ST = 4'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_e;

endpackage

// File: rtl/l1_arb_rr_arb2.sv
// rr_arb2
// Two-input round-robin picker with a last-grant register.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_valid_i    : I-client requesting
//   d_valid_i    : D-client requesting
//   commit_i     : the pick offered this cycle is being taken
//   gnt_valid_o  : at least one client is requesting
//   gnt_o        : client that wins this cycle (combinational)
// The last-grant register resets to CLIENT_D so that the I-client wins
// the first conflict after reset.
module rr_arb2
  import l1_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_valid_i,
  input  logic    d_valid_i,
  input  logic    commit_i,
  output logic    gnt_valid_o,
  output client_e gnt_o
);

  client_e last_q;
  client_e last_d;

  // On a conflict the client that did not win last time is chosen;
  // a lone requester always wins.
  always_comb begin
    gnt_valid_o = i_valid_i | d_valid_i;
    if (i_valid_i && d_valid_i) begin
      gnt_o = (last_q == CLIENT_D) ? CLIENT_I : CLIENT_D;
    end else if (d_valid_i) begin
      gnt_o = CLIENT_D;
    end else begin
      gnt_o = CLIENT_I;
    end
    last_d = last_q;
    if (commit_i && gnt_valid_o) begin
      last_d = gnt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= CLIENT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/l1_arb.sv
// l1_arb
// Merges L1 I-cache and D-cache miss/writeback requests onto the single
// L2 request port, one transaction outstanding at a time, round-robin
// on conflict, and steers each L2 response back to the issuing client.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   i_req_valid/addr, i_req_ack       : I-client request (always a load)
//   d_req_valid/addr/store_data/opcode, d_req_ack : D-client request
//   i_rsp_valid/data, d_rsp_valid/data: per-client response, data held
//   l2_req_valid/addr/store_data/opcode, l2_req_ack : L2 request port
//   l2_rsp_valid/data                 : L2 response
//   protocol_err                      : sticky, L2 response with nothing outstanding
// Optional feature macro L1_ARB_PERF_EN adds 64-bit counters
//   i_grants, d_grants, conflict_cycles.
// All outputs are registered.
module l1_arb
  import l1_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_store_data,
  input  logic [OPC_W-1:0]  d_req_opcode,
  output logic              i_req_ack,
  output logic              d_req_ack,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              l2_req_valid,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [DATA_W-1:0] l2_req_store_data,
  output logic [OPC_W-1:0]  l2_req_opcode,
  input  logic              l2_req_ack,
  input  logic              l2_rsp_valid,
  input  logic [DATA_W-1:0] l2_rsp_data,
  output logic              protocol_err
`ifdef L1_ARB_PERF_EN
  ,
  output logic [63:0]       i_grants,
  output logic [63:0]       d_grants,
  output logic [63:0]       conflict_cycles
`endif
);

  arb_state_e        state_q, state_d;
  client_e           owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic              l2_valid_q, l2_valid_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              i_rsp_valid_q, i_rsp_valid_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_W-1:0] i_rsp_data_q, i_rsp_data_d;
  logic [DATA_W-1:0] d_rsp_data_q, d_rsp_data_d;
  logic              err_q, err_d;

  logic              grant_en;
  logic              gnt_valid;
  client_e           gnt;
  logic              rsp_fire;

  rr_arb2 u_rr (
    .clk        (clk),
    .reset      (reset),
    .i_valid_i  (i_req_valid),
    .d_valid_i  (d_req_valid),
    .commit_i   (grant_en),
    .gnt_valid_o(gnt_valid),
    .gnt_o      (gnt)
  );

  // Client valids are only looked at in IDLE, so a loser that keeps its
  // valid high is simply picked up on the next return to IDLE.
  assign grant_en = (state_q == IDLE) && gnt_valid;

  // A response counts when it arrives with the accepting ack in REQ or at
  // any time in WAIT_RSP; a response in REQ before the ack is not ours.
  assign rsp_fire = ((state_q == REQ) && l2_req_ack && l2_rsp_valid) ||
                    ((state_q == WAIT_RSP) && l2_rsp_valid);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    data_d        = data_q;
    opc_d         = opc_q;
    l2_valid_d    = l2_valid_q;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    i_rsp_valid_d = 1'b0;
    d_rsp_valid_d = 1'b0;
    i_rsp_data_d  = i_rsp_data_q;
    d_rsp_data_d  = d_rsp_data_q;
    err_d         = err_q;

    case (state_q)
      IDLE: begin
        if (l2_rsp_valid) begin
          err_d = 1'b1;
        end
        if (grant_en) begin
          owner_d    = gnt;
          l2_valid_d = 1'b1;
          state_d    = REQ;
          if (gnt == CLIENT_I) begin
            addr_d  = i_req_addr;
            data_d  = '0;
            opc_d   = OPC_W'(MEM_LD);
            i_ack_d = 1'b1;
          end else begin
            addr_d  = d_req_addr;
            data_d  = d_req_store_data;
            opc_d   = d_req_opcode;
            d_ack_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (l2_req_ack) begin
          l2_valid_d = 1'b0;
          state_d    = l2_rsp_valid ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (l2_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Store responses only produce the pulse; the data register keeps
    // whatever the last load returned.
    if (rsp_fire) begin
      if (owner_q == CLIENT_I) begin
        i_rsp_valid_d = 1'b1;
        if (opc_q != OPC_W'(MEM_ST)) begin
          i_rsp_data_d = l2_rsp_data;
        end
      end else begin
        d_rsp_valid_d = 1'b1;
        if (opc_q != OPC_W'(MEM_ST)) begin
          d_rsp_data_d = l2_rsp_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= CLIENT_I;
      addr_q        <= '0;
      data_q        <= '0;
      opc_q         <= '0;
      l2_valid_q    <= 1'b0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_data_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      opc_q         <= opc_d;
      l2_valid_q    <= l2_valid_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_data_q  <= d_rsp_data_d;
      err_q         <= err_d;
    end
  end

  assign i_req_ack         = i_ack_q;
  assign d_req_ack         = d_ack_q;
  assign i_rsp_valid       = i_rsp_valid_q;
  assign d_rsp_valid       = d_rsp_valid_q;
  assign i_rsp_data        = i_rsp_data_q;
  assign d_rsp_data        = d_rsp_data_q;
  assign l2_req_valid      = l2_valid_q;
  assign l2_req_addr       = addr_q;
  assign l2_req_store_data = data_q;
  assign l2_req_opcode     = opc_q;
  assign protocol_err      = err_q;

`ifdef L1_ARB_PERF_EN
  logic [63:0] i_grants_q, d_grants_q, conflict_q;

  // Every IDLE cycle with both clients valid is also a grant cycle, so
  // conflict_cycles never exceeds i_grants + d_grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_grants_q <= '0;
      d_grants_q <= '0;
      conflict_q <= '0;
    end else begin
      if (grant_en && (gnt == CLIENT_I)) begin
        i_grants_q <= i_grants_q + 64'd1;
      end
      if (grant_en && (gnt == CLIENT_D)) begin
        d_grants_q <= d_grants_q + 64'd1;
      end
      if ((state_q == IDLE) && i_req_valid && d_req_valid) begin
        conflict_q <= conflict_q + 64'd1;
      end
    end
  end

  assign i_grants        = i_grants_q;
  assign d_grants        = d_grants_q;
  assign conflict_cycles = conflict_q;
`endif

endmodule

// File: tb/tb_l1_arb.sv
// tb_l1_arb
// Self-checking bench for l1_arb: directed scenarios followed by random
// request traffic, compared against a transaction-level reference kept in
// the bench (round-robin winner, held response data, sticky error flag).
// Builds with or without L1_ARB_PERF_EN.
module tb_l1_arb;
  import l1_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int OPC_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_store_data;
  logic [OPC_W-1:0]  d_req_opcode;
  logic              i_req_ack, d_req_ack;
  logic              i_rsp_valid, d_rsp_valid;
  logic [DATA_W-1:0] i_rsp_data, d_rsp_data;
  logic              l2_req_valid;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [DATA_W-1:0] l2_req_store_data;
  logic [OPC_W-1:0]  l2_req_opcode;
  logic              l2_req_ack;
  logic              l2_rsp_valid;
  logic [DATA_W-1:0] l2_rsp_data;
  logic              protocol_err;
`ifdef L1_ARB_PERF_EN
  logic [63:0]       i_grants, d_grants, conflict_cycles;
`endif

  always #5 clk = ~clk;

  l1_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OPC_W(OPC_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_req_valid      (i_req_valid),
    .i_req_addr       (i_req_addr),
    .d_req_valid      (d_req_valid),
    .d_req_addr       (d_req_addr),
    .d_req_store_data (d_req_store_data),
    .d_req_opcode     (d_req_opcode),
    .i_req_ack        (i_req_ack),
    .d_req_ack        (d_req_ack),
    .i_rsp_valid      (i_rsp_valid),
    .i_rsp_data       (i_rsp_data),
    .d_rsp_valid      (d_rsp_valid),
    .d_rsp_data       (d_rsp_data),
    .l2_req_valid     (l2_req_valid),
    .l2_req_addr      (l2_req_addr),
    .l2_req_store_data(l2_req_store_data),
    .l2_req_opcode    (l2_req_opcode),
    .l2_req_ack       (l2_req_ack),
    .l2_rsp_valid     (l2_rsp_valid),
    .l2_rsp_data      (l2_rsp_data),
    .protocol_err     (protocol_err)
`ifdef L1_ARB_PERF_EN
    ,
    .i_grants         (i_grants),
    .d_grants         (d_grants),
    .conflict_cycles  (conflict_cycles)
`endif
  );

  int checks = 0;
  int passes = 0;

  // Reference state: who won last, pending client requests, the data each
  // client should currently see, the sticky error and the perf counts.
  bit                lastWinnerD;
  bit                iPend, dPend;
  logic [ADDR_W-1:0] iAddr, dAddr;
  logic [DATA_W-1:0] dData;
  logic [OPC_W-1:0]  dOpc;
  logic [DATA_W-1:0] iRspExp, dRspExp;
  bit                errExp;
  longint unsigned   grantsIExp, grantsDExp, conflictsExp;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    lastWinnerD  = 1'b1;
    iPend        = 1'b0;
    dPend        = 1'b0;
    iRspExp      = '0;
    dRspExp      = '0;
    errExp       = 1'b0;
    grantsIExp   = 0;
    grantsDExp   = 0;
    conflictsExp = 0;
  endtask

  task automatic applyReset();
    reset        = 1'b1;
    i_req_valid  = 1'b0;
    d_req_valid  = 1'b0;
    l2_req_ack   = 1'b0;
    l2_rsp_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    resetModel();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_acks"}, {i_req_ack, d_req_ack}, '0);
    checkOutput({tag, "_rspv"}, {i_rsp_valid, d_rsp_valid}, '0);
    checkOutput({tag, "_irspd"}, i_rsp_data, '0);
    checkOutput({tag, "_drspd"}, d_rsp_data, '0);
    checkOutput({tag, "_l2v"}, l2_req_valid, '0);
    checkOutput({tag, "_l2a"}, l2_req_addr, '0);
    checkOutput({tag, "_l2d"}, l2_req_store_data, '0);
    checkOutput({tag, "_l2o"}, l2_req_opcode, '0);
    checkOutput({tag, "_err"}, protocol_err, '0);
`ifdef L1_ARB_PERF_EN
    checkOutput({tag, "_pi"}, i_grants, '0);
    checkOutput({tag, "_pd"}, d_grants, '0);
    checkOutput({tag, "_pc"}, conflict_cycles, '0);
`endif
  endtask

  task automatic newI();
    iPend = 1'b1;
    iAddr = $urandom;
  endtask

  task automatic newD();
    dPend = 1'b1;
    dAddr = $urandom;
    dData = {$urandom, $urandom, $urandom, $urandom};
    dOpc  = $urandom_range(0, 1) ? MEM_ST : MEM_LD;
  endtask

  // One complete transaction from the currently pending requests: optional
  // idle gap, grant, ackDelay REQ cycles before L2 accepts, then the
  // response either with the ack or rspDelay cycles later.
  task automatic applyStimulus(input int gap, input int ackDelay, input int rspDelay,
                               input bit sameCycle, input logic [DATA_W-1:0] rspData);
    bit                winD;
    bit                isStore;
    logic [ADDR_W-1:0] expAddr;
    logic [OPC_W-1:0]  expOpc;
    for (int g = 0; g < gap; g++) begin
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      step();
      checkOutput("gap_ack", {i_req_ack, d_req_ack}, '0);
      checkOutput("gap_l2v", l2_req_valid, '0);
    end
    i_req_valid      = iPend;
    d_req_valid      = dPend;
    i_req_addr       = iAddr;
    d_req_addr       = dAddr;
    d_req_store_data = dData;
    d_req_opcode     = dOpc;
    if (iPend && dPend) begin
      winD = !lastWinnerD;
      conflictsExp++;
    end else begin
      winD = dPend;
    end
    lastWinnerD = winD;
    if (winD) grantsDExp++;
    else grantsIExp++;
    expAddr = winD ? dAddr : iAddr;
    expOpc  = winD ? dOpc : MEM_LD;
    isStore = winD && (dOpc == MEM_ST);

    step();
    checkOutput("i_ack", i_req_ack, !winD);
    checkOutput("d_ack", d_req_ack, winD);
    checkOutput("l2_valid", l2_req_valid, 1);
    checkOutput("l2_addr", l2_req_addr, expAddr);
    checkOutput("l2_opc", l2_req_opcode, expOpc);
    if (winD) checkOutput("l2_data", l2_req_store_data, dData);
    checkOutput("rsp_quiet", {i_rsp_valid, d_rsp_valid}, '0);
    if (winD) begin
      d_req_valid = 1'b0;
      dPend       = 1'b0;
    end else begin
      i_req_valid = 1'b0;
      iPend       = 1'b0;
    end

    for (int k = 0; k < ackDelay; k++) begin
      step();
      checkOutput("req_hold_v", l2_req_valid, 1);
      checkOutput("req_hold_a", l2_req_addr, expAddr);
      checkOutput("req_no_ack", {i_req_ack, d_req_ack}, '0);
    end

    l2_req_ack   = 1'b1;
    l2_rsp_valid = sameCycle;
    l2_rsp_data  = rspData;
    step();
    l2_req_ack   = 1'b0;
    l2_rsp_valid = 1'b0;
    checkOutput("l2v_drop", l2_req_valid, 0);

    if (!sameCycle) begin
      checkOutput("wait_quiet", {i_rsp_valid, d_rsp_valid}, '0);
      for (int k = 0; k < rspDelay; k++) begin
        l2_req_ack  = 1'($urandom_range(0, 1));
        l2_rsp_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        checkOutput("wait_rspv", {i_rsp_valid, d_rsp_valid}, '0);
        checkOutput("wait_l2v", l2_req_valid, 0);
      end
      l2_req_ack   = 1'b0;
      l2_rsp_valid = 1'b1;
      l2_rsp_data  = rspData;
      step();
      l2_rsp_valid = 1'b0;
    end

    if (!isStore) begin
      if (winD) dRspExp = rspData;
      else iRspExp = rspData;
    end
    checkOutput("i_rspv", i_rsp_valid, !winD);
    checkOutput("d_rspv", d_rsp_valid, winD);
    checkOutput("i_rspd", i_rsp_data, iRspExp);
    checkOutput("d_rspd", d_rsp_data, dRspExp);
    checkOutput("err", protocol_err, errExp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_req_addr       = '0;
    d_req_addr       = '0;
    d_req_store_data = '0;
    d_req_opcode     = '0;
    l2_rsp_data      = '0;
    iAddr            = '0;
    dAddr            = '0;
    dData            = '0;
    dOpc             = MEM_LD;
    applyReset();
    checkResetOutputs("rst");

    // I load, L2 acks two cycles after grant and answers three later
    iPend = 1'b1;
    iAddr = 32'h0000_1000;
    applyStimulus(0, 1, 2, 1'b0, {16{8'hAA}});
    checkOutput("t1_data", i_rsp_data, {16{8'hAA}});

    // D store with ack and response together, then an immediate new grant
    dPend = 1'b1;
    dAddr = 32'h0000_2040;
    dData = {4{32'hDEAD_BEEF}};
    dOpc  = MEM_ST;
    applyStimulus(0, 2, 0, 1'b1, {4{32'h1234_5678}});
    iPend = 1'b1;
    iAddr = 32'h0000_3000;
    applyStimulus(0, 0, 1, 1'b0, {4{32'h0BAD_F00D}});

    // Both clients valid from reset: I, D, I, D
    applyReset();
    iPend = 1'b1;
    iAddr = 32'h0000_A000;
    dPend = 1'b1;
    dAddr = 32'h0000_B000;
    dData = '0;
    dOpc  = MEM_LD;
    applyStimulus(0, 0, 1, 1'b0, {4{32'h1111_1111}});
    checkOutput("rr_1", lastWinnerD, 0);
    iPend = 1'b1;
    iAddr = 32'h0000_A100;
    applyStimulus(0, 1, 0, 1'b0, {4{32'h2222_2222}});
    checkOutput("rr_2", lastWinnerD, 1);
    dPend = 1'b1;
    dAddr = 32'h0000_B100;
    applyStimulus(0, 0, 0, 1'b1, {4{32'h3333_3333}});
    checkOutput("rr_3", lastWinnerD, 0);
    applyStimulus(0, 2, 2, 1'b0, {4{32'h4444_4444}});
    checkOutput("rr_4", lastWinnerD, 1);
`ifdef L1_ARB_PERF_EN
    checkOutput("perf_conf", conflict_cycles, 3);
    checkOutput("perf_i", i_grants, grantsIExp);
    checkOutput("perf_d", d_grants, grantsDExp);
    checkOutput("perf_conf_m", conflict_cycles, conflictsExp);
`endif

    // Stray L2 response while idle
    l2_rsp_valid = 1'b1;
    l2_rsp_data  = {4{32'hFFFF_0000}};
    step();
    l2_rsp_valid = 1'b0;
    errExp       = 1'b1;
    checkOutput("stray_err", protocol_err, 1);
    checkOutput("stray_rspv", {i_rsp_valid, d_rsp_valid}, '0);
    checkOutput("stray_irspd", i_rsp_data, iRspExp);
    step();
    checkOutput("stray_sticky", protocol_err, 1);

    // Reset while waiting for a response, then a late response
    applyReset();
    dAddr            = 32'h0000_2000;
    d_req_addr       = dAddr;
    d_req_opcode     = MEM_LD;
    d_req_store_data = '0;
    d_req_valid      = 1'b1;
    step();
    checkOutput("wr_d_ack", d_req_ack, 1);
    d_req_valid = 1'b0;
    l2_req_ack  = 1'b1;
    step();
    l2_req_ack = 1'b0;
    checkOutput("wr_l2v", l2_req_valid, 0);
    step();
    reset = 1'b1;
    step();
    checkResetOutputs("mid_rst");
    reset = 1'b0;
    resetModel();
    l2_rsp_valid = 1'b1;
    l2_rsp_data  = {4{32'h5555_AAAA}};
    step();
    l2_rsp_valid = 1'b0;
    checkOutput("late_err", protocol_err, 1);
    checkOutput("late_rspv", {i_rsp_valid, d_rsp_valid}, '0);
    checkOutput("late_drspd", d_rsp_data, '0);

    // Random traffic
    applyReset();
    for (int t = 0; t < 40; t++) begin
      int gap;
      int sel;
      if (iPend || dPend) begin
        gap = 0;
        if (!iPend && ($urandom_range(0, 1) == 1)) newI();
        if (!dPend && ($urandom_range(0, 1) == 1)) newD();
      end else begin
        gap = $urandom_range(0, 2);
        sel = $urandom_range(1, 3);
        if ((sel & 1) != 0) newI();
        if ((sel & 2) != 0) newD();
      end
      applyStimulus(gap, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end
    while (iPend || dPend) begin
      applyStimulus(0, $urandom_range(0, 2), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end
`ifdef L1_ARB_PERF_EN
    checkOutput("rnd_perf_i", i_grants, grantsIExp);
    checkOutput("rnd_perf_d", d_grants, grantsDExp);
    checkOutput("rnd_perf_c", conflict_cycles, conflictsExp);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
